mem_port_arbiter: RTL and testbench

//  Shares one backing memory port (dmem-style: en/we/addr/wdata, 64-bit rdata) between the

---
 rtl/mem_port_arbiter_pkg.sv | 17 +
 rtl/mem_port_arbiter_rr_arbiter_2.sv | 22 ++
 rtl/mem_port_arbiter.sv | 120 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings and widths for the I/D memory port arbiter.
package mem_port_arbiter_pkg;
   localparam int ADDR_W  = 64;
   localparam int DATA_W  = 64;
   localparam int INSTR_W = 32;
   localparam int CNT_W   = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   // Owner code doubles as the bit index into the 2-bit request/grant vectors.
   localparam logic OWN_I = 1'b0;
   localparam logic OWN_D = 1'b1;
endpackage

// File: rtl/mem_port_arbiter_rr_arbiter_2.sv
// Two-way combinational arbiter: bit 0 = fetch, bit 1 = data.
module rr_arbiter_2
   import mem_port_arbiter_pkg::*;
(
   input  logic [1:0] req_i,
   input  logic       ptr_i,
   input  logic       prio_mode_i,
   output logic [1:0] gnt_o,
   output logic       next_ptr_o
);
   always_comb begin
      gnt_o      = req_i;
      next_ptr_o = ptr_i;
      if (req_i == 2'b11) begin
         gnt_o = (prio_mode_i || ptr_i == OWN_D) ? 2'b10 : 2'b01;
      end
      // Round-robin hands preference to whoever lost this grant.
      if (!prio_mode_i && gnt_o != 2'b00) begin
         next_ptr_o = gnt_o[OWN_I] ? OWN_D : OWN_I;
      end
   end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between instruction fetch and load/store.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int MEM_LAT   = 1,
   parameter bit PRIO_MODE = 1'b0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               i_req,
   input  logic [ADDR_W-1:0]  i_addr,
   output logic               i_gnt,
   output logic               i_rvalid,
   output logic [INSTR_W-1:0] i_rdata,
   input  logic               d_req,
   input  logic               d_we,
   input  logic [ADDR_W-1:0]  d_addr,
   input  logic [DATA_W-1:0]  d_wdata,
   output logic               d_gnt,
   output logic               d_rvalid,
   output logic [DATA_W-1:0]  d_rdata,
   output logic               m_en,
   output logic               m_we,
   output logic [ADDR_W-1:0]  m_addr,
   output logic [DATA_W-1:0]  m_wd,
   input  logic [DATA_W-1:0]  m_rd
);
   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               owner_q, we_q, rr_ptr_q;
   logic [ADDR_W-1:0]  addr_q;
   logic [DATA_W-1:0]  wdata_q;
   logic [INSTR_W-1:0] i_rdata_q;
   logic [DATA_W-1:0]  d_rdata_q;
   logic [1:0]         arb_req, arb_gnt;
   logic               next_ptr, grant, last_cyc;

   // Grants only in IDLE and never while reset is asserted.
   assign arb_req = {d_req, i_req} & {2{(state_q == ST_IDLE) && !reset}};

   rr_arbiter_2 u_arb (
      .req_i       (arb_req),
      .ptr_i       (rr_ptr_q),
      .prio_mode_i (PRIO_MODE),
      .gnt_o       (arb_gnt),
      .next_ptr_o  (next_ptr)
   );

   assign grant    = |arb_gnt;
   assign last_cyc = (state_q == ST_ACCESS) && (cnt_q == '0);
   assign i_gnt    = arb_gnt[OWN_I];
   assign d_gnt    = arb_gnt[OWN_D];
   assign i_rdata  = i_rdata_q;
   assign d_rdata  = d_rdata_q;
   assign m_wd     = wdata_q;
   assign m_addr   = (owner_q == OWN_D) ? {addr_q[ADDR_W-1:3], 3'b000}
                                        : {addr_q[ADDR_W-1:2], 2'b00};

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      m_en     = 1'b0;
      m_we     = 1'b0;
      i_rvalid = 1'b0;
      d_rvalid = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (grant) begin
               state_d = ST_ACCESS;
               cnt_d   = CNT_W'(MEM_LAT - 1);
            end
         end
         ST_ACCESS: begin
            m_en = 1'b1;
            if (cnt_q == '0) begin
               // Reset wins over a store strobe landing in the same cycle.
               m_we    = we_q & ~reset;
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_RESP: begin
            i_rvalid = (owner_q == OWN_I);
            d_rvalid = (owner_q == OWN_D);
            state_d  = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         owner_q   <= OWN_I;
         we_q      <= 1'b0;
         rr_ptr_q  <= OWN_I;
         addr_q    <= '0;
         wdata_q   <= '0;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (grant) begin
            owner_q  <= arb_gnt[OWN_D];
            we_q     <= arb_gnt[OWN_D] & d_we;
            addr_q   <= arb_gnt[OWN_D] ? d_addr : i_addr;
            wdata_q  <= arb_gnt[OWN_D] ? d_wdata : '0;
            rr_ptr_q <= next_ptr;
         end
         // Result registers load only for their own owner, so each holds across the other's accesses.
         if (last_cyc) begin
            if (owner_q == OWN_I) i_rdata_q <= addr_q[2] ? m_rd[63:32] : m_rd[31:0];
            else                  d_rdata_q <= we_q ? '0 : m_rd;
         end
      end
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: three arbiter instances (LAT1/RR, LAT3/RR, LAT4/D-prio) on shared stimulus.
module tb_mem_port_arbiter;
   localparam int NI = 3;
   localparam logic [11:0] LATS  = {4'd4, 4'd3, 4'd1};
   localparam logic [2:0]  PRIOS = 3'b100;

   logic clk = 1'b0, reset = 1'b1, mem_init = 1'b0;
   logic i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
   logic [63:0] i_addr = '0, d_addr = '0, d_wdata = '0;
   logic i_gnt [NI], i_rvalid [NI], d_gnt [NI], d_rvalid [NI], m_en [NI], m_we [NI];
   logic [31:0] i_rdata [NI];
   logic [63:0] d_rdata [NI], m_addr [NI], m_wd [NI], m_rd [NI];
   int n_tests = 0, n_fail = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      logic [63:0] mem [16];
      mem_port_arbiter #(.MEM_LAT(int'(LATS[g*4 +: 4])), .PRIO_MODE(PRIOS[g])) dut (
         .clk(clk), .reset(reset),
         .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt[g]), .i_rvalid(i_rvalid[g]), .i_rdata(i_rdata[g]),
         .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
         .d_gnt(d_gnt[g]), .d_rvalid(d_rvalid[g]), .d_rdata(d_rdata[g]),
         .m_en(m_en[g]), .m_we(m_we[g]), .m_addr(m_addr[g]), .m_wd(m_wd[g]), .m_rd(m_rd[g])
      );
      assign m_rd[g] = mem[m_addr[g][6:3]];
      always @(posedge clk) begin
         if (mem_init) begin
            for (int i = 0; i < 16; i++) mem[i] <= (i == 0) ? 64'hAAAA_BBBB_CCCC_DDDD : {32'(i), 32'(i)};
         end else if (m_en[g] && m_we[g]) begin
            mem[m_addr[g][6:3]] <= m_wd[g];
         end
      end
   end

   task automatic step(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      step(2);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; i_req = 1'b1; d_req = 1'b1; i_addr = 64'h0; d_addr = 64'h8; d_we = 1'b0; mem_init = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step(1); mem_init = 1'b0;
         n_tests++;
         if ({i_gnt[0], d_gnt[0], m_en[0], m_we[0], i_rvalid[0], d_rvalid[0]} !== 6'b0) begin
            n_fail++; $display("FAIL reset_ctrl c%0d: got %b exp 000000", c,
                               {i_gnt[0], d_gnt[0], m_en[0], m_we[0], i_rvalid[0], d_rvalid[0]});
         end
         n_tests++;
         if (i_rdata[0] !== 32'h0 || d_rdata[0] !== 64'h0 || m_addr[0] !== 64'h0 || m_wd[0] !== 64'h0) begin
            n_fail++; $display("FAIL reset_data c%0d: got %h %h %h exp zeros", c, i_rdata[0], d_rdata[0], m_addr[0]);
         end
      end
      reset = 1'b0; #1;
      n_tests++;
      if ({i_gnt[0], d_gnt[0]} !== 2'b10) begin
         n_fail++; $display("FAIL reset_first_gnt: got i/d=%b exp 10", {i_gnt[0], d_gnt[0]});
      end
      step(1); i_req = 1'b0; d_req = 1'b0;
   endtask

   task automatic test_fetch();
      do_reset();
      i_addr = 64'h4; i_req = 1'b1; #1;
      n_tests++; if (i_gnt[0] !== 1'b1) begin n_fail++; $display("FAIL fetch_gnt: got %b exp 1", i_gnt[0]); end
      step(1); i_req = 1'b0; #1;
      n_tests++;
      if (m_en[0] !== 1'b1 || m_addr[0] !== 64'h4 || i_rvalid[0] !== 1'b0) begin
         n_fail++; $display("FAIL fetch_access: got en=%b addr=%h rv=%b exp 1 4 0", m_en[0], m_addr[0], i_rvalid[0]);
      end
      step(1);
      n_tests++;
      if (i_rvalid[0] !== 1'b1 || i_rdata[0] !== 32'hAAAA_BBBB || m_en[0] !== 1'b0) begin
         n_fail++; $display("FAIL fetch_hi: got rv=%b data=%h en=%b exp 1 aaaabbbb 0", i_rvalid[0], i_rdata[0], m_en[0]);
      end
      step(1);
      n_tests++; if (i_rvalid[0] !== 1'b0) begin n_fail++; $display("FAIL fetch_rv_pulse: got %b exp 0", i_rvalid[0]); end
      i_addr = 64'h0; i_req = 1'b1; #1;
      n_tests++; if (i_gnt[0] !== 1'b1) begin n_fail++; $display("FAIL fetch2_gnt: got %b exp 1", i_gnt[0]); end
      step(1); i_req = 1'b0;
      step(1);
      n_tests++;
      if (i_rvalid[0] !== 1'b1 || i_rdata[0] !== 32'hCCCC_DDDD) begin
         n_fail++; $display("FAIL fetch_lo: got rv=%b data=%h exp 1 ccccdddd", i_rvalid[0], i_rdata[0]);
      end
   endtask

   task automatic test_store_load();
      do_reset();
      d_we = 1'b1; d_addr = 64'h18; d_wdata = 64'h1234; d_req = 1'b1; #1;
      n_tests++; if (d_gnt[1] !== 1'b1) begin n_fail++; $display("FAIL store_gnt: got %b exp 1", d_gnt[1]); end
      step(1); d_req = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         #1;
         n_tests++;
         if (m_en[1] !== 1'b1 || m_we[1] !== (k == 3) || m_addr[1] !== 64'h18 || d_rvalid[1] !== 1'b0) begin
            n_fail++; $display("FAIL store_access T+%0d: got en=%b we=%b addr=%h exp 1 %0d 18", k, m_en[1], m_we[1], m_addr[1], k == 3);
         end
         if (k == 3) begin
            n_tests++; if (m_wd[1] !== 64'h1234) begin n_fail++; $display("FAIL store_wd: got %h exp 1234", m_wd[1]); end
         end
         step(1);
      end
      n_tests++;
      if (d_rvalid[1] !== 1'b1 || d_rdata[1] !== 64'h0 || m_we[1] !== 1'b0) begin
         n_fail++; $display("FAIL store_resp: got rv=%b data=%h we=%b exp 1 0 0", d_rvalid[1], d_rdata[1], m_we[1]);
      end
      step(1);
      n_tests++; if (g_dut[1].mem[3] !== 64'h1234) begin n_fail++; $display("FAIL store_mem: got %h exp 1234", g_dut[1].mem[3]); end
      d_we = 1'b0; d_req = 1'b1; #1;
      n_tests++; if (d_gnt[1] !== 1'b1) begin n_fail++; $display("FAIL load_gnt: got %b exp 1", d_gnt[1]); end
      step(1); d_req = 1'b0;
      step(3);
      n_tests++;
      if (d_rvalid[1] !== 1'b1 || d_rdata[1] !== 64'h1234) begin
         n_fail++; $display("FAIL load_data: got rv=%b data=%h exp 1 1234", d_rvalid[1], d_rdata[1]);
      end
   endtask

   task automatic test_arbitration();
      logic ebi, ebd, ebir, ebdr, ecd;
      do_reset();
      i_addr = 64'h0; d_addr = 64'h8; d_we = 1'b0; i_req = 1'b1; d_req = 1'b1;
      for (int c = 0; c < 30; c++) begin
         #1;
         ebi = (c % 10 == 0); ebd = (c % 10 == 5); ebir = (c % 10 == 4); ebdr = (c % 10 == 9);
         ecd = (c % 6 == 0);
         n_tests++;
         if ({i_gnt[1], d_gnt[1], i_rvalid[1], d_rvalid[1]} !== {ebi, ebd, ebir, ebdr}) begin
            n_fail++; $display("FAIL rr c%0d: got gi/gd/ri/rd=%b exp %b", c,
                               {i_gnt[1], d_gnt[1], i_rvalid[1], d_rvalid[1]}, {ebi, ebd, ebir, ebdr});
         end
         n_tests++;
         if ({i_gnt[2], d_gnt[2]} !== {1'b0, ecd}) begin
            n_fail++; $display("FAIL prio c%0d: got gi/gd=%b exp %b", c, {i_gnt[2], d_gnt[2]}, {1'b0, ecd});
         end
         step(1);
      end
      d_req = 1'b0; #1;
      n_tests++;
      if (i_gnt[2] !== 1'b1 || i_gnt[1] !== 1'b1) begin
         n_fail++; $display("FAIL starve_release: got prio=%b rr=%b exp 1 1", i_gnt[2], i_gnt[1]);
      end
      step(1); i_req = 1'b0;
   endtask

   task automatic test_reset_mid_access();
      do_reset();
      d_we = 1'b1; d_addr = 64'h20; d_wdata = 64'hDEAD_BEEF; d_req = 1'b1; #1;
      n_tests++; if (d_gnt[2] !== 1'b1) begin n_fail++; $display("FAIL abort_gnt: got %b exp 1", d_gnt[2]); end
      step(1); d_req = 1'b0;
      step(1); reset = 1'b1; #1;
      n_tests++; if (m_en[2] !== 1'b1 || m_we[2] !== 1'b0) begin n_fail++; $display("FAIL abort_c2: got en=%b we=%b exp 1 0", m_en[2], m_we[2]); end
      step(1); reset = 1'b0;
      for (int k = 3; k <= 6; k++) begin
         #1;
         n_tests++;
         if ({m_en[2], m_we[2], d_rvalid[2]} !== 3'b000) begin
            n_fail++; $display("FAIL abort_quiet T+%0d: got en/we/rv=%b exp 000", k, {m_en[2], m_we[2], d_rvalid[2]});
         end
         step(1);
      end
      n_tests++; if (g_dut[2].mem[4] !== {32'd4, 32'd4}) begin n_fail++; $display("FAIL abort_mem: got %h exp 0000000400000004", g_dut[2].mem[4]); end
      i_req = 1'b1; #1;
      n_tests++; if (i_gnt[2] !== 1'b1) begin n_fail++; $display("FAIL abort_idle_gnt: got %b exp 1", i_gnt[2]); end
      step(1); i_req = 1'b0;
      step(6);
      d_req = 1'b1; #1;
      n_tests++; if (d_gnt[2] !== 1'b1) begin n_fail++; $display("FAIL strobe_gnt: got %b exp 1", d_gnt[2]); end
      step(1); d_req = 1'b0;
      step(3); reset = 1'b1; #1;
      n_tests++;
      if (m_en[2] !== 1'b1 || m_we[2] !== 1'b0) begin
         n_fail++; $display("FAIL strobe_suppress: got en=%b we=%b exp 1 0", m_en[2], m_we[2]);
      end
      step(1); reset = 1'b0; #1;
      n_tests++;
      if ({m_en[2], d_rvalid[2]} !== 2'b00 || g_dut[2].mem[4] !== {32'd4, 32'd4}) begin
         n_fail++; $display("FAIL strobe_after: got en/rv=%b mem=%h exp 00 0000000400000004", {m_en[2], d_rvalid[2]}, g_dut[2].mem[4]);
      end
   endtask

   task automatic test_wait_during_access();
      do_reset();
      i_addr = 64'h0; i_req = 1'b1; #1;
      n_tests++; if (i_gnt[0] !== 1'b1) begin n_fail++; $display("FAIL wait_ignt: got %b exp 1", i_gnt[0]); end
      step(1); i_req = 1'b0; d_we = 1'b0; d_addr = 64'h8; d_req = 1'b1; #1;
      n_tests++; if (d_gnt[0] !== 1'b0) begin n_fail++; $display("FAIL wait_access_dgnt: got %b exp 0", d_gnt[0]); end
      step(1);
      n_tests++;
      if (d_gnt[0] !== 1'b0 || i_rvalid[0] !== 1'b1 || i_rdata[0] !== 32'hCCCC_DDDD) begin
         n_fail++; $display("FAIL wait_resp: got dg=%b rv=%b data=%h exp 0 1 ccccdddd", d_gnt[0], i_rvalid[0], i_rdata[0]);
      end
      step(1);
      n_tests++; if (d_gnt[0] !== 1'b1) begin n_fail++; $display("FAIL wait_dgnt_idle: got %b exp 1", d_gnt[0]); end
      step(1); d_req = 1'b0;
      step(1);
      n_tests++;
      if (d_rvalid[0] !== 1'b1 || d_rdata[0] !== {32'd1, 32'd1} || i_rdata[0] !== 32'hCCCC_DDDD) begin
         n_fail++; $display("FAIL wait_dload: got rv=%b d=%h i=%h exp 1 0000000100000001 ccccdddd", d_rvalid[0], d_rdata[0], i_rdata[0]);
      end
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_store_load();
      test_arbitration();
      test_reset_mid_access();
      test_wait_during_access();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
